// File: rtl/exa_vc_fifo_if.sv
// Handshake/status bundle for the multi-VC FIFO: one write port, one read port,
// per-VC status vectors and sticky error flags.
interface exa_vc_fifo_if #(
   parameter int VC_NUM = 4,
   parameter int DEPTH  = 16,
   parameter int DWIDTH = 32
);
   localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int DL   = $clog2(DEPTH);

   logic                         i_wr_en;
   logic [VC_W-1:0]              i_wr_vc;
   logic [DWIDTH-1:0]            i_wr_data;
   logic [VC_NUM-1:0]            o_full;
   logic [VC_NUM-1:0]            o_prog_full;
   logic [VC_NUM*(DL+1)-1:0]     o_wr_words;
   logic                         i_rd_en;
   logic [VC_W-1:0]              i_rd_vc;
   logic [DWIDTH-1:0]            o_rd_data;
   logic [VC_NUM-1:0]            o_empty;
   logic                         o_err_ovf;
   logic                         o_err_udf;
   logic                         o_err_vc;

   modport master (
      output i_wr_en, i_wr_vc, i_wr_data, i_rd_en, i_rd_vc,
      input  o_full, o_prog_full, o_wr_words, o_rd_data, o_empty,
             o_err_ovf, o_err_udf, o_err_vc
   );

   modport slave (
      input  i_wr_en, i_wr_vc, i_wr_data, i_rd_en, i_rd_vc,
      output o_full, o_prog_full, o_wr_words, o_rd_data, o_empty,
             o_err_ovf, o_err_udf, o_err_vc
   );
endinterface

// File: rtl/exa_vc_fifo.sv
// Multi-VC synchronous FIFO: VC_NUM queues in one partitioned memory, first-word
// fall-through read, per-VC registered status and sticky error flags.
module exa_vc_fifo_ctl #(
   parameter int DEPTH            = 16,
   parameter int DL               = $clog2(DEPTH),
   parameter int PROG_FULL_ASSERT = 4,
   parameter int PROG_FULL_NEGATE = 8
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        wr_acc,
   input  logic        rd_acc,
   output logic [DL:0] wr_ptr,
   output logic [DL:0] rd_ptr,
   output logic        empty,
   output logic        full,
   output logic        prog_full,
   output logic [DL:0] free
);
   localparam logic [DL:0] DEPTH_W = (DL+1)'(DEPTH);
   localparam logic [DL:0] PFA_W   = (DL+1)'(PROG_FULL_ASSERT);
   localparam logic [DL:0] PFN_W   = (DL+1)'(PROG_FULL_NEGATE);

   logic [DL:0] wr_nxt, rd_nxt, free_nxt;
   logic        pf_nxt;

   // Flags are derived from next-state pointers so they register in step with them
   always_comb begin
      wr_nxt   = wr_ptr + (DL+1)'(wr_acc);
      rd_nxt   = rd_ptr + (DL+1)'(rd_acc);
      free_nxt = DEPTH_W - (wr_nxt - rd_nxt);
      pf_nxt   = prog_full;
      if (free_nxt <= PFA_W)      pf_nxt = 1'b1;
      else if (free_nxt >= PFN_W) pf_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         prog_full <= 1'b0;
         free      <= DEPTH_W;
      end else begin
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         empty     <= (wr_nxt == rd_nxt);
         full      <= (wr_nxt[DL] != rd_nxt[DL]) && (wr_nxt[DL-1:0] == rd_nxt[DL-1:0]);
         prog_full <= pf_nxt;
         free      <= free_nxt;
      end
   end
endmodule

module exa_vc_fifo #(
   parameter int VC_NUM           = 4,
   parameter int DEPTH            = 16,
   parameter int DWIDTH           = 32,
   parameter int PROG_FULL_ASSERT = 4,
   parameter int PROG_FULL_NEGATE = 8,
   parameter int DISTRIBUTED      = 1
) (
   input  logic         clk,
   input  logic         arst_n,
   exa_vc_fifo_if.slave bus
);
   localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int DL   = $clog2(DEPTH);
   localparam int VC_P = 1 << VC_W;
   localparam int AW   = VC_W + DL;

   logic [VC_NUM-1:0]         wr_acc_v, rd_acc_v, full, empty, prog_full;
   logic [VC_NUM-1:0][DL:0]   wr_ptr, rd_ptr, free;
   // Views padded to the full VC index range so out-of-range VCs read as harmless zeros
   logic [VC_P-1:0]           vc_ok, full_x, empty_x;
   logic [VC_P-1:0][DL:0]     wr_ptr_x, rd_ptr_x;
   logic                      wr_ok, rd_ok, wr_acc, rd_acc;
   logic [AW-1:0]             waddr, raddr;
   logic                      err_ovf, err_udf, err_vc;

   for (genvar k = 0; k < VC_P; k++) begin : g_pad
      if (k < VC_NUM) begin : g_live
         assign vc_ok[k]    = 1'b1;
         assign full_x[k]   = full[k];
         assign empty_x[k]  = empty[k];
         assign wr_ptr_x[k] = wr_ptr[k];
         assign rd_ptr_x[k] = rd_ptr[k];
         assign wr_acc_v[k] = wr_acc && (bus.i_wr_vc == VC_W'(k));
         assign rd_acc_v[k] = rd_acc && (bus.i_rd_vc == VC_W'(k));
      end else begin : g_dead
         assign vc_ok[k]    = 1'b0;
         assign full_x[k]   = 1'b0;
         assign empty_x[k]  = 1'b0;
         assign wr_ptr_x[k] = '0;
         assign rd_ptr_x[k] = '0;
      end
   end

   assign wr_ok  = bus.i_wr_en && vc_ok[bus.i_wr_vc];
   assign rd_ok  = bus.i_rd_en && vc_ok[bus.i_rd_vc];
   assign wr_acc = wr_ok && !full_x[bus.i_wr_vc];
   assign rd_acc = rd_ok && !empty_x[bus.i_rd_vc];

   exa_vc_fifo_ctl #(
      .DEPTH(DEPTH), .DL(DL),
      .PROG_FULL_ASSERT(PROG_FULL_ASSERT), .PROG_FULL_NEGATE(PROG_FULL_NEGATE)
   ) u_ctl [VC_NUM-1:0] (
      .clk(clk), .arst_n(arst_n),
      .wr_acc(wr_acc_v), .rd_acc(rd_acc_v),
      .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
      .empty(empty), .full(full), .prog_full(prog_full), .free(free)
   );

   // VC number forms the upper address bits since DEPTH is a power of two
   assign waddr = {bus.i_wr_vc, wr_ptr_x[bus.i_wr_vc][DL-1:0]};
   assign raddr = {bus.i_rd_vc, rd_ptr_x[bus.i_rd_vc][DL-1:0]};

   if (DISTRIBUTED != 0) begin : g_dist
      (* ram_style = "distributed" *) logic [DWIDTH-1:0] mem [VC_NUM*DEPTH];
      always_ff @(posedge clk) if (wr_acc) mem[waddr] <= bus.i_wr_data;
      assign bus.o_rd_data = mem[raddr];
   end else begin : g_bram
      (* ram_style = "block" *) logic [DWIDTH-1:0] mem [VC_NUM*DEPTH];
      always_ff @(posedge clk) if (wr_acc) mem[waddr] <= bus.i_wr_data;
      assign bus.o_rd_data = mem[raddr];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
         err_vc  <= 1'b0;
      end else begin
         if (wr_ok && full_x[bus.i_wr_vc])  err_ovf <= 1'b1;
         if (rd_ok && empty_x[bus.i_rd_vc]) err_udf <= 1'b1;
         if ((bus.i_wr_en && !vc_ok[bus.i_wr_vc]) || (bus.i_rd_en && !vc_ok[bus.i_rd_vc]))
            err_vc <= 1'b1;
      end
   end

   assign bus.o_full      = full;
   assign bus.o_empty     = empty;
   assign bus.o_prog_full = prog_full;
   assign bus.o_wr_words  = free;
   assign bus.o_err_ovf   = err_ovf;
   assign bus.o_err_udf   = err_udf;
   assign bus.o_err_vc    = err_vc;
endmodule
